// File: rtl/imm_field_encoder_if.sv
// Streaming request/response bundle for imm_field_encoder.
// master = request producer and result consumer, slave = the encoder.
interface imm_field_encoder_if #(
    parameter int ERR_W = 8
);
    // Valid/ready rule on both channels: a beat transfers on a rising clk edge
    // where valid & ready are both 1; a valid beat holds its payload until then.
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       immSrc;
    logic [31:0]      imm;
    logic [24:0]      base;
    logic             err_clr;
    logic             out_valid;
    logic             out_ready;
    logic [24:0]      out;
    logic             out_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, immSrc, imm, base, err_clr, out_ready,
        input  in_ready, out_valid, out, out_err, err_count
    );

    modport slave (
        input  in_valid, immSrc, imm, base, err_clr, out_ready,
        output in_ready, out_valid, out, out_err, err_count
    );
endinterface

// File: rtl/imm_field_encoder.sv
// Packs a 32-bit immediate into instr[31:7] for I/S/B/U/J formats with range checking.
// Optional IMM_ENC_STRICT_EN: erroneous requests are consumed silently and out_err is tied 0.
module imm_field_encoder #(
    parameter int ERR_W = 8
) (
    input logic               clk,
    input logic               rst,
    imm_field_encoder_if.slave bus
);

    typedef struct packed {
        logic [24:0] field;
        logic        err;
    } pack_t;

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    function automatic pack_t pack_imm(input logic [2:0] src, input logic [31:0] imm,
                                       input logic [24:0] base);
        pack_t p;
        p.field = base;
        p.err   = 1'b1;
        case (src)
            SRC_I: begin
                p.field = {imm[11:0], base[12:0]};
                p.err   = !((&imm[31:11]) || !(|imm[31:11]));
            end
            SRC_S: begin
                p.field = {imm[11:5], base[17:5], imm[4:0]};
                p.err   = !((&imm[31:11]) || !(|imm[31:11]));
            end
            SRC_B: begin
                p.field = {imm[12], imm[10:5], base[17:5], imm[4:1], imm[11]};
                p.err   = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            end
            SRC_U: begin
                p.field = {imm[31:12], base[4:0]};
                p.err   = |imm[11:0];
            end
            SRC_J: begin
                p.field = {imm[20], imm[10:1], imm[11], imm[19:12], base[4:0]};
                p.err   = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            end
            default: begin
                p.field = base;
                p.err   = 1'b1;
            end
        endcase
        return p;
    endfunction

    pack_t            w_pack;
    logic             w_accept;
    logic             w_push;
    logic             w_err_bit;
    logic             w_main_free;
    logic             w_inc;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [24:0]      r_out;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [24:0]      r_skid_field;
    logic             r_skid_err;
    logic [ERR_W-1:0] r_err_count;

    assign w_pack      = pack_imm(bus.immSrc, bus.imm, bus.base);
    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_inc       = w_accept & w_pack.err;
    assign w_main_free = ~r_out_valid | bus.out_ready;

`ifdef IMM_ENC_STRICT_EN
    assign w_push    = w_accept & ~w_pack.err;
    assign w_err_bit = 1'b0;
`else
    assign w_push    = w_accept;
    assign w_err_bit = w_pack.err;
`endif

    // in_ready mirrors "skid empty"; a new beat can only arrive while the skid is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_field <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out        <= r_skid_field;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_out_valid <= w_push;
                if (w_push) begin
                    r_out     <= w_pack.field;
                    r_out_err <= w_err_bit;
                end
            end
        end else if (w_push) begin
            r_skid_valid <= 1'b1;
            r_skid_field <= w_pack.field;
            r_skid_err   <= w_err_bit;
            r_in_ready   <= 1'b0;
        end
    end

    // A clear that coincides with a counted error leaves that error counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (bus.err_clr) begin
            r_err_count <= w_inc ? CNT_ONE : '0;
        end else if (w_inc && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_ONE;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_err   = r_out_err;
    assign bus.err_count = r_err_count;

endmodule
